tc_fadd_s1: RTL

- First stage of the tensor-core fused add. Directly downstream of the multiplier's final stage: it consumes the unrounded product (sign/exp/sig plus NaN/Inf/invalid/overflow flags) together with addend C.
- Unpacks C, picks the larger-exponent operand, and right-aligns the smaller significand with sticky collection.
- Registers the result behind a valid/ready handshake for the next fadd stage.
- Latency 1 cycle, throughput 1 per cycle.

---
 rtl/tc_fadd_s1_pkg.sv | 51 +++++
 rtl/tc_fadd_s1_shift_right_sticky.sv | 29 ++
 rtl/tc_fadd_s1.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tc_fadd_s1_pkg.sv
// Shared definitions for the tensor-core fused-add pipeline: rounding-mode
// encodings, derived significand widths and IEEE unpack helpers.
package tc_fadd_s1_pkg;

  // Rounding modes as carried down the fused-add pipeline.
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Guard, round and sticky bits appended below the product-scale significand.
  localparam int unsigned GRS_BITS = 3;

  // Product-scale significand width (hidden bit included).
  function automatic int unsigned calc_sigw(input int unsigned precision);
    return 2 * precision;
  endfunction

  // Aligned significand width: product-scale significand plus G/R/S.
  function automatic int unsigned calc_alignw(input int unsigned precision);
    return 2 * precision + GRS_BITS;
  endfunction

  // Classification of a packed IEEE operand. exp_zero marks zero/subnormal,
  // which drives both the hidden bit and the effective exponent.
  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_inf;
    logic exp_zero;
  } fp_class_t;

  // Width-independent classifier: callers reduce exponent/fraction first.
  function automatic fp_class_t fp_classify(
    input logic exp_all_ones,
    input logic exp_all_zero,
    input logic frac_zero,
    input logic frac_msb
  );
    fp_class_t cls;
    cls.is_nan   = exp_all_ones && !frac_zero;
    cls.is_snan  = exp_all_ones && !frac_zero && !frac_msb;
    cls.is_inf   = exp_all_ones && frac_zero;
    cls.exp_zero = exp_all_zero;
    return cls;
  endfunction

endpackage

// File: rtl/tc_fadd_s1_shift_right_sticky.sv
// Logical right shift that also reports whether any set bit fell off the
// bottom. Shift amounts at or beyond the width yield zero data and the OR of
// the whole input as sticky.
module tc_fadd_s1_shift_right_sticky #(
  parameter int W   = 51,
  parameter int SHW = 9
) (
  input  logic [W-1:0]   data,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   shifted,
  output logic           sticky
);

  logic [31:0]  shamt_ext;
  logic [W-1:0] lost_mask;

  assign shamt_ext = 32'(shamt);

  // Bit gi is lost whenever it sits below the shift amount.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_lost_mask
      assign lost_mask[gi] = (32'(gi) < shamt_ext);
    end
  endgenerate

  assign shifted = data >> shamt;
  assign sticky  = |(data & lost_mask);

endmodule

// File: rtl/tc_fadd_s1.sv
// Fused-add stage 1: unpacks addend C, picks the larger-exponent operand
// against the unrounded product, right-aligns the smaller significand with
// sticky collection and registers the result behind a valid/ready handshake.
module tc_fadd_s1
  import tc_fadd_s1_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24,
  parameter int TAGW      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic                                   prod_sign_i,
  input  logic [EXPWIDTH-1:0]                    prod_exp_i,
  input  logic [2*PRECISION-2:0]                 prod_sig_i,
  input  logic                                   prod_is_nan_i,
  input  logic                                   prod_is_inf_i,
  input  logic                                   prod_is_inv_i,
  input  logic                                   prod_overflow_i,
  input  logic [EXPWIDTH+PRECISION-1:0]          c_i,
  input  logic [2:0]                             rm_i,
  input  logic [TAGW-1:0]                        tag_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic                                   out_sign_big_o,
  output logic [EXPWIDTH-1:0]                    out_exp_big_o,
  output logic [2*PRECISION+GRS_BITS-1:0]        out_sig_big_o,
  output logic [2*PRECISION+GRS_BITS-1:0]        out_sig_small_o,
  output logic                                   out_eff_sub_o,
  output logic                                   out_is_nan_o,
  output logic                                   out_is_inf_o,
  output logic                                   out_is_inv_o,
  output logic                                   out_overflow_o,
  output logic [2:0]                             out_rm_o,
  output logic [TAGW-1:0]                        out_tag_o
);

  localparam int SIGW   = int'(calc_sigw(PRECISION));
  localparam int ALIGNW = int'(calc_alignw(PRECISION));
  localparam int FRACW  = PRECISION - 1;
  localparam int DIFFW  = EXPWIDTH + 1;

  // ---------------- addend unpack ----------------
  logic                c_sign;
  logic [EXPWIDTH-1:0] c_exp;
  logic [FRACW-1:0]    c_frac;
  fp_class_t           c_class;

  assign c_sign  = c_i[EXPWIDTH+PRECISION-1];
  assign c_exp   = c_i[FRACW +: EXPWIDTH];
  assign c_frac  = c_i[FRACW-1:0];
  assign c_class = fp_classify(&c_exp, c_exp == '0, c_frac == '0, c_frac[FRACW-1]);

  // Both mantissas at product scale; C's fraction sits just under its hidden bit.
  logic [SIGW-1:0]     prod_mant;
  logic [SIGW-1:0]     c_mant;
  logic [EXPWIDTH-1:0] prod_eexp;
  logic [EXPWIDTH-1:0] c_eexp;

  assign prod_mant = {prod_exp_i != '0, prod_sig_i};
  assign c_mant    = {!c_class.exp_zero, c_frac, {PRECISION{1'b0}}};
  // Subnormals share the scale of exponent 1.
  assign prod_eexp = (prod_exp_i == '0) ? EXPWIDTH'(1) : prod_exp_i;
  assign c_eexp    = c_class.exp_zero ? EXPWIDTH'(1) : c_exp;

  // ---------------- operand selection ----------------
  logic                prod_is_big;
  logic                sign_big;
  logic [EXPWIDTH-1:0] exp_big;
  logic [EXPWIDTH-1:0] exp_small;
  logic [SIGW-1:0]     mant_big;
  logic [SIGW-1:0]     mant_small;

  // Ties go to the product so equal-exponent cases never shift the product.
  assign prod_is_big = (prod_eexp >= c_eexp);

  // Route the larger-exponent operand to the big path.
  always_comb begin
    sign_big   = prod_sign_i;
    exp_big    = prod_eexp;
    exp_small  = c_eexp;
    mant_big   = prod_mant;
    mant_small = c_mant;
    if (!prod_is_big) begin
      sign_big   = c_sign;
      exp_big    = c_eexp;
      exp_small  = prod_eexp;
      mant_big   = c_mant;
      mant_small = prod_mant;
    end
  end

  // ---------------- alignment ----------------
  logic [DIFFW-1:0]  exp_diff;
  logic [ALIGNW-1:0] small_shifted;
  logic              small_sticky;
  logic [ALIGNW-1:0] sig_big_next;
  logic [ALIGNW-1:0] sig_small_next;

  assign exp_diff = {1'b0, exp_big} - {1'b0, exp_small};

  tc_fadd_s1_shift_right_sticky #(
    .W   (ALIGNW),
    .SHW (DIFFW)
  ) u_align (
    .data    ({mant_small, {GRS_BITS{1'b0}}}),
    .shamt   (exp_diff),
    .shifted (small_shifted),
    .sticky  (small_sticky)
  );

  assign sig_big_next   = {mant_big, {GRS_BITS{1'b0}}};
  assign sig_small_next = small_shifted | ALIGNW'(small_sticky);

  // ---------------- special-case flags ----------------
  logic nan_next;
  logic inv_next;
  logic inf_next;
  logic eff_sub_next;

  assign eff_sub_next = prod_sign_i ^ c_sign;
  assign nan_next     = prod_is_nan_i || c_class.is_nan;
  assign inv_next     = prod_is_inv_i || c_class.is_snan ||
                        (prod_is_inf_i && c_class.is_inf && eff_sub_next);
  assign inf_next     = !nan_next && (prod_is_inf_i || c_class.is_inf);

  // ---------------- handshake register ----------------
  logic valid_reg;
  logic valid_next;
  logic load;

  assign in_ready_o = !valid_reg || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Valid sets on a load, clears when drained with nothing new arriving.
  always_comb begin
    valid_next = valid_reg;
    if (load) begin
      valid_next = 1'b1;
    end else if (out_ready_i) begin
      valid_next = 1'b0;
    end
  end

  // Valid flag; reset drops any held entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  logic                sign_big_reg;
  logic [EXPWIDTH-1:0] exp_big_reg;
  logic [ALIGNW-1:0]   sig_big_reg;
  logic [ALIGNW-1:0]   sig_small_reg;
  logic                eff_sub_reg;
  logic                nan_reg;
  logic                inf_reg;
  logic                inv_reg;
  logic                overflow_reg;
  logic [2:0]          rm_reg;
  logic [TAGW-1:0]     tag_reg;

  // Payload loads only on an accepted transfer, so it holds during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_big_reg  <= 1'b0;
      exp_big_reg   <= '0;
      sig_big_reg   <= '0;
      sig_small_reg <= '0;
      eff_sub_reg   <= 1'b0;
      nan_reg       <= 1'b0;
      inf_reg       <= 1'b0;
      inv_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
      rm_reg        <= '0;
      tag_reg       <= '0;
    end else if (load) begin
      sign_big_reg  <= sign_big;
      exp_big_reg   <= exp_big;
      sig_big_reg   <= sig_big_next;
      sig_small_reg <= sig_small_next;
      eff_sub_reg   <= eff_sub_next;
      nan_reg       <= nan_next;
      inf_reg       <= inf_next;
      inv_reg       <= inv_next;
      overflow_reg  <= prod_overflow_i;
      rm_reg        <= rm_i;
      tag_reg       <= tag_i;
    end
  end

  assign out_valid_o     = valid_reg;
  assign out_sign_big_o  = sign_big_reg;
  assign out_exp_big_o   = exp_big_reg;
  assign out_sig_big_o   = sig_big_reg;
  assign out_sig_small_o = sig_small_reg;
  assign out_eff_sub_o   = eff_sub_reg;
  assign out_is_nan_o    = nan_reg;
  assign out_is_inf_o    = inf_reg;
  assign out_is_inv_o    = inv_reg;
  assign out_overflow_o  = overflow_reg;
  assign out_rm_o        = rm_reg;
  assign out_tag_o       = tag_reg;

endmodule
